// File: rtl/serial_mult_param_if.sv
`default_nettype none
// ============================================================================
// serial_mult_param_if : framed serial input / product output bundle
// Rev 1.0
// ============================================================================
interface serial_mult_param_if #(
  parameter int W = 16
);
  logic           start;
  logic           signed_mode;
  logic           in_bit;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] prod;
  logic           prod_valid;
  logic           err;
  logic           busy;

  modport master (
    output start, signed_mode, in_bit, in_valid,
    input  in_ready, prod, prod_valid, err, busy
  );

  modport slave (
    input  start, signed_mode, in_bit, in_valid,
    output in_ready, prod, prod_valid, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_mult_param.sv
`default_nettype none
// ============================================================================
// serial_mult_param : bit-serial shift-and-add multiplier, framed length field
// Rev 1.0
// ============================================================================
module serial_mult_param #(
  parameter int W     = 16,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  serial_mult_param_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_MPLR = 3'd2;
  localparam logic [2:0] S_MCND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [LEN_W-1:0] c_LEN_LAST = LEN_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] c_W_MAX    = LEN_W'(W);
  localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_signed;
  logic [W-1:0]     r_mplr;
  logic [2*W-1:0]   r_mplr_ext;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_prod;
  logic             r_prod_valid;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last_bit;
  logic [LEN_W-1:0] w_len_shift;
  logic [W-1:0]     w_mplr_bits;
  logic [2*W-1:0]   w_mplr_ext;
  logic [2*W-1:0]   w_term;
  logic [2*W-1:0]   w_acc_next;

  assign w_in_ready  = (r_state == S_LEN) || (r_state == S_MPLR) || (r_state == S_MCND);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_last_bit  = (r_cnt == (r_len - c_ONE));
  assign w_len_shift = {bus.in_bit, r_len[LEN_W-1:1]};

  // Multiplier bits land at their own index; bits at and above len are the sign.
  assign w_mplr_bits = r_mplr | ({{(W-1){1'b0}}, bus.in_bit} << r_cnt);
  assign w_mplr_ext  = {{W{1'b0}}, w_mplr_bits} |
                       ((r_signed & bus.in_bit) ? ({(2*W){1'b1}} << r_len) : '0);

  assign w_term = r_mplr_ext << r_cnt;

  // The multiplicand MSB carries negative weight in two's complement.
  always_comb begin
    w_acc_next = r_acc;
    if (bus.in_bit) begin
      if (r_signed && w_last_bit) begin
        w_acc_next = r_acc - w_term;
      end else begin
        w_acc_next = r_acc + w_term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_signed     <= 1'b0;
      r_mplr       <= '0;
      r_mplr_ext   <= '0;
      r_acc        <= '0;
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prod_valid <= 1'b0;
      r_err        <= 1'b0;
      if (bus.start) begin
        // Start from any state begins a fresh frame and silently drops the old one.
        r_state    <= S_LEN;
        r_cnt      <= '0;
        r_len      <= '0;
        r_mplr     <= '0;
        r_mplr_ext <= '0;
        r_acc      <= '0;
        r_signed   <= bus.signed_mode;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_LEN: begin
            if (w_accept) begin
              r_len <= w_len_shift;
              if (r_cnt == c_LEN_LAST) begin
                r_cnt <= '0;
                if ((w_len_shift == '0) || (w_len_shift > c_W_MAX)) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                end else begin
                  r_state <= S_MPLR;
                end
              end else begin
                r_cnt <= r_cnt + c_ONE;
              end
            end
          end
          S_MPLR: begin
            if (w_accept) begin
              r_mplr <= w_mplr_bits;
              if (w_last_bit) begin
                r_mplr_ext <= w_mplr_ext;
                r_cnt      <= '0;
                r_state    <= S_MCND;
              end else begin
                r_cnt <= r_cnt + c_ONE;
              end
            end
          end
          S_MCND: begin
            if (w_accept) begin
              r_acc <= w_acc_next;
              if (w_last_bit) begin
                r_prod       <= w_acc_next;
                r_prod_valid <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_cnt <= r_cnt + c_ONE;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.prod       = r_prod;
  assign bus.prod_valid = r_prod_valid;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_mult_param.sv
`default_nettype none
// ============================================================================
// tb_serial_mult_param : directed vectors for serial_mult_param at W=8
// Rev 1.0
// ============================================================================
module tb_serial_mult_param;

  localparam int c_W     = 8;
  localparam int c_LEN_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   cyc0;
  int   pv_cnt;
  int   pv0;

  serial_mult_param_if #(.W(c_W)) bus ();

  serial_mult_param #(.W(c_W), .LEN_W(c_LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.prod_valid) pv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic sgn);
    bus.start       = 1'b1;
    bus.signed_mode = sgn;
    bus.in_valid    = 1'b0;
    tick();
    bus.start = 1'b0;
    cyc0      = cyc;
  endtask

  // Sends n bits LSB first; stall_at >= 0 inserts three idle cycles before that bit.
  task automatic send_bits(input logic [15:0] val, input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.in_valid = 1'b0;
        repeat (3) tick();
      end
      bus.in_bit   = val[i];
      bus.in_valid = 1'b1;
      tick();
    end
  endtask

  task automatic frame(input logic sgn, input int len, input logic [15:0] a, input logic [15:0] b);
    do_start(sgn);
    send_bits(16'(len), c_LEN_W, -1);
    send_bits(a, len, -1);
    send_bits(b, len, -1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; cyc0 = 0; pv_cnt = 0; pv0 = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.in_bit = 1'b0; bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_prod", 32'(bus.prod), 32'h0);
    check("rst_pv", 32'(bus.prod_valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_rdy", 32'(bus.in_ready), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);

    // Unsigned 13 x 11
    frame(1'b0, 4, 16'd13, 16'd11);
    check("u_prod", 32'(bus.prod), 32'h008F);
    check("u_pv", 32'(bus.prod_valid), 32'h1);
    check("u_lat", 32'(cyc - cyc0), 32'd12);
    check("u_rdy_done", 32'(bus.in_ready), 32'h0);
    check("u_busy_done", 32'(bus.busy), 32'h1);
    tick();
    check("u_pv_strobe", 32'(bus.prod_valid), 32'h0);
    check("u_idle", 32'(bus.busy), 32'h0);

    // Signed -3 x 5 and -128 x -128
    frame(1'b1, 4, 16'h000D, 16'h0005);
    check("s_neg_prod", 32'(bus.prod), 32'hFFF1);
    check("s_neg_pv", 32'(bus.prod_valid), 32'h1);
    tick();
    frame(1'b1, 8, 16'h0080, 16'h0080);
    check("s_min_prod", 32'(bus.prod), 32'h4000);
    tick();

    // Illegal lengths
    for (int k = 0; k < 2; k++) begin
      do_start(1'b0);
      send_bits((k == 0) ? 16'd0 : 16'd9, c_LEN_W, -1);
      bus.in_valid = 1'b0;
      check("len_err", 32'(bus.err), 32'h1);
      check("len_err_pv", 32'(bus.prod_valid), 32'h0);
      check("len_err_lat", 32'(cyc - cyc0), 32'd4);
      check("len_err_idle", 32'(bus.busy), 32'h0);
      check("len_err_prod", 32'(bus.prod), 32'h4000);
      tick();
      check("len_err_strobe", 32'(bus.err), 32'h0);
    end

    // 255 x 255 with a 3-cycle stall in each field
    do_start(1'b0);
    send_bits(16'd8, c_LEN_W, 2);
    send_bits(16'd255, 8, 5);
    send_bits(16'd255, 8, 3);
    bus.in_valid = 1'b0;
    check("stall_prod", 32'(bus.prod), 32'hFE01);
    check("stall_pv", 32'(bus.prod_valid), 32'h1);
    check("stall_lat", 32'(cyc - cyc0), 32'd29);
    tick();

    // Abort during MCND, then 6 x 7
    pv0 = pv_cnt;
    do_start(1'b0);
    send_bits(16'd4, c_LEN_W, -1);
    send_bits(16'd13, 4, -1);
    send_bits(16'd11, 2, -1);
    frame(1'b0, 4, 16'd6, 16'd7);
    tick();
    check("abort_prod", 32'(bus.prod), 32'h002A);
    check("abort_pv_count", 32'(pv_cnt - pv0), 32'd1);

    // Start coinciding with the final multiplicand bit wins
    do_start(1'b0);
    send_bits(16'd2, c_LEN_W, -1);
    send_bits(16'd2, 2, -1);
    send_bits(16'd3, 1, -1);
    bus.start = 1'b1; bus.in_bit = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    check("startwins_pv", 32'(bus.prod_valid), 32'h0);
    check("startwins_prod", 32'(bus.prod), 32'h002A);
    check("startwins_rdy", 32'(bus.in_ready), 32'h1);

    // Reset mid-MPLR, then 2 x 3
    do_start(1'b0);
    send_bits(16'd4, c_LEN_W, -1);
    send_bits(16'd9, 2, -1);
    rst = 1'b1; bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst_prod", 32'(bus.prod), 32'h0);
    check("mrst_pv", 32'(bus.prod_valid), 32'h0);
    check("mrst_err", 32'(bus.err), 32'h0);
    check("mrst_rdy", 32'(bus.in_ready), 32'h0);
    check("mrst_busy", 32'(bus.busy), 32'h0);
    frame(1'b0, 2, 16'd2, 16'd3);
    check("post_rst_prod", 32'(bus.prod), 32'h0006);
    check("post_rst_pv", 32'(bus.prod_valid), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_mult_param.md
# serial_mult_param

Parametrised bit-serial multiplier. It accepts a framed serial stream on a single data line: a length field, then the multiplier, then the multiplicand, each LSB first. It produces a 2W-bit product by shift-and-add, one multiplicand bit per accepted input bit. Compared with the fixed 32-bit serial multiplier, it adds:
- a width parameter,
- a per-frame signed/unsigned mode,
- a valid/ready input handshake,
- explicit start/abort framing,
- a product-valid strobe,
- length error detection.

## Interface
- W, 16: maximum operand width in bits (≥2).
- LEN_W, $clog2(W+1): width of the serial length field.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  frame start / abort pulse.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- in_bit  in  1  serial data.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  block accepts a bit this cycle.
- prod  out  2W  product, held until the next prod_valid.
- prod_valid  out  1  one-cycle strobe: prod updated.
- err  out  1  one-cycle strobe: illegal length, frame dropped.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LEN, MPLR, MCND, DONE.
- A bit is accepted on an edge where in_valid & in_ready. in_ready = 1 in LEN, MPLR and MCND only.
- IDLE:
  - start → LEN.
  - Clear the bit counter, the length register and the accumulator.
  - Latch signed_mode.
  - in_bit is ignored in the start cycle.
- LEN: shift LEN_W accepted bits LSB first into len.
  - After the last length bit: if len == 0 or len > W, pulse err and go to IDLE.
  - Otherwise go to MPLR.
- MPLR: shift len accepted bits into the multiplier.
  - After bit len-1, form mplr_ext (2W bits):
    - signed: sign-extended from bit len-1;
    - unsigned: zero-extended.
  - Go to MCND.
- MCND: for accepted bit i (i = 0..len-1):
  - If bit = 1: acc += mplr_ext << i.
  - Exception: signed mode and i = len-1 → acc -= mplr_ext << i. This is the two's-complement MSB weight.
  - All arithmetic is modulo 2^(2W). The true product always fits 2W bits.
  - On the edge accepting bit len-1: prod ← final acc (including that bit's term), prod_valid ← 1, go to DONE.
- DONE: one cycle, in_ready = 0, then IDLE.
- start in LEN/MPLR/MCND/DONE aborts the current frame and restarts at LEN.
  - Re-latch signed_mode and clear the counters and accumulator.
  - No prod_valid or err is raised for the aborted frame.
- start in the same cycle as a final-bit acceptance: start wins. The frame is aborted and prod is not updated.
- in_valid low stalls the frame with no state change, for any number of cycles.

## Timing
- Reset values: prod = 0, prod_valid = 0, err = 0, in_ready = 0, busy = 0, state = IDLE, internal registers = 0.
- Reset mid-frame discards everything and returns to IDLE on the next edge.
- With start at edge t and in_valid held high:
  - length bits are accepted at edges t+1 .. t+LEN_W;
  - multiplier bits at t+LEN_W+1 .. t+LEN_W+len;
  - multiplicand bits at t+LEN_W+len+1 .. t+LEN_W+2·len.
- prod_valid is high for the single cycle after the edge at t+LEN_W+2·len. The state is DONE in that cycle.
- err is high for the single cycle after edge t+LEN_W.
- Throughput: the next start is honoured from the DONE cycle onward, so frames can run back-to-back.
- prod_valid and err are never high together.

## Test plan
W=8, LEN_W=4, in_valid continuous unless stated.
- Unsigned, len=4, mplr=13 (1101), mcnd=11 (1011) → prod=0x008F one cycle after edge t+12; in_ready low in that cycle.
- Signed, len=4, mplr=-3 (1101), mcnd=5 (0101) → prod=0xFFF1 (-15). Also signed len=8, -128 × -128 → prod=0x4000.
- len=0 and len=9 → err pulses once after edge t+4; prod keeps its previous value; state returns to IDLE.
- Unsigned len=8, 255 × 255, with in_valid dropped for 3 cycles at random points in each field → prod=0xFE01. Completion is delayed by exactly the stall cycles.
- Abort: start again during MCND of a 13 × 11 frame, then run 6 × 7 → a single prod_valid with prod=0x002A.
- rst asserted mid-MPLR → all outputs at reset values next cycle. A following 2 × 3 frame yields 0x0006.
